// File: rtl/cp0_unit.sv
// CP0 register file for the MEM/WB stage: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// interrupt request and exception vector generation. Optional EBase register under CP0_EBASE_EN.
module cp0_unit #(
  parameter int unsigned HW_INT_N   = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter int unsigned TIMER_LINE = 5,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [2:0]          wsel,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  input  logic [2:0]          rsel,
  output logic [31:0]         rdata,
  input  logic [HW_INT_N-1:0] int_i,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         badvaddr_o,
  output logic                timer_int_o,
  output logic                int_req_o,
  output logic [31:0]         exc_vector_o
);

  localparam int unsigned     PRE_W       = 4;
  localparam int unsigned     IP_HW_W     = 6;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(COUNT_DIV - 1);
  localparam logic [31:0]     STATUS_MASK = 32'h0040_FF03;
  localparam logic [31:0]     STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0]     VEC_BEV     = 32'hBFC0_0380;
  localparam logic [31:0]     VEC_NORM    = 32'h8000_0180;

  logic [31:0]         count_q, compare_q, status_q, epc_q, badvaddr_q;
  logic [PRE_W-1:0]    pre_q;
  logic [IP_HW_W-1:0]  ip_hw_q;
  logic [1:0]          ip_sw_q;
  logic                ti_q, bd_q, int_req_q;
  logic [4:0]          exc_code_q;

  logic                mtc, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [IP_HW_W-1:0]  ip_hw_t;
  logic [7:0]          ip;
  logic [31:0]         cause_w, status_d;
  logic                int_req_d;

`ifdef CP0_EBASE_EN
  logic [17:0]         ebase_q;
  logic [31:0]         ebase_w;
  logic                wr_ebase;
  assign ebase_w  = {2'b10, ebase_q, 12'h000};
  assign wr_ebase = mtc && (waddr == 5'd15) && (wsel == 3'd1);
`endif

  // A committing exception squashes any MTC0 issued alongside it
  always_comb begin
    mtc        = we & ~exc_valid;
    wr_count   = mtc && (waddr == 5'd9)  && (wsel == 3'd0);
    wr_compare = mtc && (waddr == 5'd11) && (wsel == 3'd0);
    wr_status  = mtc && (waddr == 5'd12) && (wsel == 3'd0);
    wr_cause   = mtc && (waddr == 5'd13) && (wsel == 3'd0);
    wr_epc     = mtc && (waddr == 5'd14) && (wsel == 3'd0);
  end

  // Cause view: timer flag folds into its hardware IP line
  always_comb begin
    ip_hw_t                    = ip_hw_q;
    ip_hw_t[3'(TIMER_LINE)]    = ip_hw_q[3'(TIMER_LINE)] | ti_q;
    ip                         = {ip_hw_t, ip_sw_q};
    cause_w                    = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b00};
    int_req_d                  = (|(ip & status_q[15:8])) & status_q[0] & ~status_q[1];
  end

  // Exception commit forces EXL; ERET clears it after any same-cycle MTC0
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = wdata & STATUS_MASK;
    if (exc_valid)  status_d[1] = 1'b1;
    else if (eret)  status_d[1] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
    end else if (wr_count) begin
      count_q <= wdata;
      pre_q   <= '0;
    end else if (pre_q == PRE_MAX) begin
      count_q <= count_q + 32'd1;
      pre_q   <= '0;
    end else begin
      pre_q   <= pre_q + PRE_W'(1);
    end
  end

  // TI is sticky; a Compare write wins over a simultaneous match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      if (wr_compare) compare_q <= wdata;
      if (wr_compare)                  ti_q <= 1'b0;
      else if (count_q == compare_q)   ti_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      int_req_q  <= 1'b0;
    end else begin
      status_q   <= status_d;
      ip_hw_q    <= IP_HW_W'(int_i);
      if (wr_cause) ip_sw_q <= wdata[9:8];
      int_req_q  <= int_req_d;
    end
  end

  // EPC/BD are frozen while already inside a handler (EXL=1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q      <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      badvaddr_q <= '0;
    end else if (exc_valid) begin
      if (!status_q[1]) begin
        epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_q  <= exc_bd;
      end
      exc_code_q <= exc_code;
      if ((exc_code == 5'd4) || (exc_code == 5'd5)) badvaddr_q <= exc_badvaddr;
    end else if (wr_epc) begin
      epc_q <= wdata;
    end
  end

`ifdef CP0_EBASE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ebase_q <= '0;
    else if (wr_ebase) ebase_q <= wdata[29:12];
  end
  assign exc_vector_o = status_q[22] ? VEC_BEV : {ebase_w[31:12], 12'h180};
`else
  assign exc_vector_o = status_q[22] ? VEC_BEV : VEC_NORM;
`endif

  // Read port sees pre-write state
  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        5'd8:    rdata = badvaddr_q;
        5'd9:    rdata = count_q;
        5'd11:   rdata = compare_q;
        5'd12:   rdata = status_q;
        5'd13:   rdata = cause_w;
        5'd14:   rdata = epc_q;
        5'd15:   rdata = PRID_VAL;
        5'd16:   rdata = CONFIG_VAL;
        default: rdata = '0;
      endcase
    end
`ifdef CP0_EBASE_EN
    else if ((rsel == 3'd1) && (raddr == 5'd15)) begin
      rdata = ebase_w;
    end
`endif
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_w;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = ti_q;
  assign int_req_o   = int_req_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_cp0_unit;
  localparam int unsigned HW_INT_N   = 6;
  localparam int unsigned COUNT_DIV  = 2;
  localparam int unsigned TIMER_LINE = 5;
  localparam logic [31:0] PRID       = 32'h004C0102;
  localparam logic [31:0] CONFIG     = 32'h00008000;

  logic clk = 1'b0, rst = 1'b1, we = 1'b0, exc_valid = 1'b0, exc_bd = 1'b0, eret = 1'b0;
  logic [4:0]  waddr = '0, raddr = '0, exc_code = '0;
  logic [2:0]  wsel = '0, rsel = '0;
  logic [31:0] wdata = '0, exc_pc = '0, exc_badvaddr = '0;
  logic [HW_INT_N-1:0] int_i = '0;
  logic [31:0] rdata, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, exc_vector_o;
  logic        timer_int_o, int_req_o;

  cp0_unit #(.HW_INT_N(HW_INT_N), .COUNT_DIV(COUNT_DIV), .TIMER_LINE(TIMER_LINE),
             .PRID_VAL(PRID), .CONFIG_VAL(CONFIG)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata), .int_i(int_i),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret),
    .count_o(count_o), .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o),
    .int_req_o(int_req_o), .exc_vector_o(exc_vector_o));

  always #5 clk = ~clk;

  typedef struct {
    logic rst, we, exc_valid, exc_bd, eret;
    logic [4:0] waddr, raddr, exc_code;
    logic [2:0] wsel, rsel;
    logic [31:0] wdata, exc_pc, exc_bva;
    logic [HW_INT_N-1:0] int_i;
  } stim_t;

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, bva, vec, rdata;
    logic ti, ireq;
  } exp_t;

  exp_t  sb[$];
  int    tests = 0, fails = 0;
  stim_t prev;

  // Behavioural model state, kept as named architectural fields
  logic [31:0] m_count, m_cmp, m_epc, m_bva, m_ebase;
  int          m_pre;
  logic        m_bev, m_exl, m_ie, m_ti, m_bd, m_ireq;
  logic [7:0]  m_im;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_iphw;
  logic [4:0]  m_code;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {9'b0, m_bev, 6'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_iphw, m_ipsw} | (8'(m_ti) << (TIMER_LINE + 2));
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_vec();
    if (m_bev) return 32'hBFC00380;
`ifdef CP0_EBASE_EN
    return {m_ebase[31:12], 12'h180};
`else
    return 32'h80000180;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s == 3'd0) begin
      case (a)
        5'd8:  return m_bva;
        5'd9:  return m_count;
        5'd11: return m_cmp;
        5'd12: return m_status();
        5'd13: return m_cause();
        5'd14: return m_epc;
        5'd15: return PRID;
        5'd16: return CONFIG;
        default: return 32'h0;
      endcase
    end
`ifdef CP0_EBASE_EN
    if (s == 3'd1 && a == 5'd15) return m_ebase;
`endif
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_count = 0; m_cmp = 0; m_epc = 0; m_bva = 0; m_pre = 0; m_ebase = 32'h80000000;
    m_bev = 1; m_exl = 0; m_ie = 0; m_im = 0; m_ti = 0; m_bd = 0; m_ireq = 0;
    m_ipsw = 0; m_iphw = 0; m_code = 0;
  endtask

  // One clock edge of architectural behaviour, all decisions on pre-edge values
  task automatic m_step(input stim_t s);
    logic mt, old_exl, new_ireq;
    logic [31:0] old_count, old_cmp;
    mt        = s.we && !s.exc_valid;
    old_exl   = m_exl;
    old_count = m_count;
    old_cmp   = m_cmp;
    new_ireq  = ((m_ip() & m_im) != 8'h0) && m_ie && !m_exl;
    if (mt && s.wsel == 0 && s.waddr == 11) m_ti = 0;
    else if (old_count == old_cmp)          m_ti = 1;
    if (mt && s.wsel == 0 && s.waddr == 9) begin
      m_count = s.wdata; m_pre = 0;
    end else if (m_pre == int'(COUNT_DIV) - 1) begin
      m_count = m_count + 1; m_pre = 0;
    end else m_pre++;
    if (mt && s.wsel == 0 && s.waddr == 11) m_cmp = s.wdata;
    if (mt && s.wsel == 0 && s.waddr == 12) begin
      m_bev = s.wdata[22]; m_im = s.wdata[15:8]; m_exl = s.wdata[1]; m_ie = s.wdata[0];
    end
    if (mt && s.wsel == 0 && s.waddr == 13) m_ipsw = s.wdata[9:8];
    if (mt && s.wsel == 0 && s.waddr == 14) m_epc = s.wdata;
    if (mt && s.wsel == 1 && s.waddr == 15) m_ebase = 32'h80000000 | (s.wdata & 32'h3FFFF000);
    if (s.exc_valid) begin
      if (!old_exl) begin
        m_epc = s.exc_bd ? s.exc_pc - 4 : s.exc_pc;
        m_bd  = s.exc_bd;
      end
      m_code = s.exc_code;
      m_exl  = 1;
      if (s.exc_code == 4 || s.exc_code == 5) m_bva = s.exc_bva;
    end else if (s.eret) m_exl = 0;
    m_iphw = 6'(s.int_i);
    m_ireq = new_ireq;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t wr(input logic [4:0] a, input logic [2:0] sl, input logic [31:0] d);
    stim_t s;
    s = idle();
    s.we = 1; s.waddr = a; s.wsel = sl; s.wdata = d;
    return s;
  endfunction

  function automatic stim_t exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                                input logic [31:0] bva);
    stim_t s;
    s = idle();
    s.exc_valid = 1; s.exc_code = c; s.exc_pc = pc; s.exc_bd = bd; s.exc_bva = bva;
    return s;
  endfunction

  // Driver: advance model over the edge, apply new inputs, push expected post-edge view
  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    if (!prev.rst) m_step(prev);
    rst = s.rst; we = s.we; waddr = s.waddr; wsel = s.wsel; wdata = s.wdata;
    raddr = s.raddr; rsel = s.rsel; int_i = s.int_i; exc_valid = s.exc_valid;
    exc_code = s.exc_code; exc_pc = s.exc_pc; exc_bd = s.exc_bd;
    exc_badvaddr = s.exc_bva; eret = s.eret;
    prev = s;
    if (s.rst) m_reset();
    e.count = m_count; e.compare = m_cmp; e.status = m_status(); e.cause = m_cause();
    e.epc = m_epc; e.bva = m_bva; e.vec = m_vec(); e.rdata = m_read(s.raddr, s.rsel);
    e.ti = m_ti; e.ireq = m_ireq;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT against each queued expectation on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_count",    count_o,           e.count);
      chk("sb_compare",  compare_o,         e.compare);
      chk("sb_status",   status_o,          e.status);
      chk("sb_cause",    cause_o,           e.cause);
      chk("sb_epc",      epc_o,             e.epc);
      chk("sb_badvaddr", badvaddr_o,        e.bva);
      chk("sb_vector",   exc_vector_o,      e.vec);
      chk("sb_rdata",    rdata,             e.rdata);
      chk("sb_ti",       32'(timer_int_o),  32'(e.ti));
      chk("sb_int_req",  32'(int_req_o),    32'(e.ireq));
    end
  end

  initial begin : stimulus
    stim_t s;
    logic [HW_INT_N-1:0] irq;
    bit seen;
    m_reset();
    prev = idle();
    prev.rst = 1;
    irq = '0;

    s = idle(); s.rst = 1;
    cyc(s); cyc(s);
    @(negedge clk);
    chk("rst_status", status_o, 32'h00400000);
    chk("rst_vector", exc_vector_o, 32'hBFC00380);
    chk("rst_count", count_o, 32'h0);
    chk("rst_int_req", 32'(int_req_o), 32'h0);

    cyc(idle());
    repeat (20) cyc(idle());
    @(negedge clk);
    chk("count_after_20", count_o, 32'd10);

    cyc(wr(9, 0, 32'hFFFFFFFF));
    repeat (3) cyc(idle());
    @(negedge clk);
    chk("count_wrap", count_o, 32'd0);

    cyc(wr(12, 0, 32'h00008001));
    cyc(wr(9, 0, 32'h0));
    cyc(wr(11, 0, 32'd5));
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(idle());
      @(negedge clk);
      if (timer_int_o) seen = 1;
    end
    chk("ti_rise", 32'(timer_int_o), 32'h1);
    chk("ti_count", count_o, 32'd5);
    cyc(idle());
    @(negedge clk);
    chk("int_req_set", 32'(int_req_o), 32'h1);
    chk("ti_hold", 32'(timer_int_o), 32'h1);
    cyc(wr(11, 0, 32'd100));
    cyc(idle());
    @(negedge clk);
    chk("ti_clear", 32'(timer_int_o), 32'h0);
    cyc(idle());
    @(negedge clk);
    chk("int_req_clear", 32'(int_req_o), 32'h0);

    cyc(exc(4, 32'hBFC00104, 1, 32'h1003));
    cyc(idle());
    @(negedge clk);
    chk("exc_epc_bd", epc_o, 32'hBFC00100);
    chk("exc_cause_bd_code", cause_o & 32'h8000007C, 32'h80000010);
    chk("exc_badvaddr", badvaddr_o, 32'h1003);
    chk("exc_exl", status_o & 32'h2, 32'h2);

    cyc(exc(8, 32'h80000200, 0, 32'h5555));
    cyc(idle());
    @(negedge clk);
    chk("nest_epc", epc_o, 32'hBFC00100);
    chk("nest_code", (cause_o >> 2) & 32'h1F, 32'd8);
    chk("nest_badvaddr", badvaddr_o, 32'h1003);
    s = idle(); s.eret = 1;
    cyc(s);
    cyc(idle());
    @(negedge clk);
    chk("eret_status", status_o, 32'h00008001);

    s = exc(0, 32'h80000400, 0, 32'h0);
    s.we = 1; s.waddr = 12; s.wdata = 32'h0;
    cyc(s);
    cyc(idle());
    @(negedge clk);
    chk("exc_squash_mtc0", status_o, 32'h00008003);
    s = idle(); s.eret = 1;
    cyc(s);
    cyc(wr(13, 0, 32'hFFFFFFFF));
    cyc(idle());
    @(negedge clk);
    chk("cause_wmask", cause_o, 32'h00000300);

    cyc(wr(12, 0, 32'h0));
    s = idle(); s.raddr = 15;
    cyc(s);
    @(negedge clk);
    chk("vector_bev0", exc_vector_o, 32'h80000180);
    chk("prid_read", rdata, PRID);
    cyc(wr(15, 1, 32'h9FC01000));
    s = idle(); s.raddr = 15; s.rsel = 1;
    cyc(s);
    @(negedge clk);
`ifdef CP0_EBASE_EN
    chk("ebase_read", rdata, 32'h9FC01000);
    chk("ebase_vector", exc_vector_o, 32'h9FC01180);
`else
    chk("ebase_absent_read", rdata, 32'h0);
    chk("ebase_absent_vector", exc_vector_o, 32'h80000180);
`endif

    for (int i = 0; i < 3000; i++) begin
      s = idle();
      if ($urandom_range(0, 7) == 0) irq = HW_INT_N'($urandom);
      s.int_i = irq;
      s.rst = ($urandom_range(0, 299) == 0);
      s.we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: s.waddr = 8;  1: s.waddr = 9;  2: s.waddr = 11; 3: s.waddr = 12;
        4: s.waddr = 13; 5: s.waddr = 14; 6: s.waddr = 15; 7: s.waddr = 16;
        default: s.waddr = 5'($urandom);
      endcase
      s.wsel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      s.wdata = $urandom;
      if (s.waddr == 9 && $urandom_range(0, 1) == 1) s.wdata = m_cmp - 32'($urandom_range(0, 6));
      s.raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 16));
      s.rsel = ($urandom_range(0, 5) == 0) ? 3'd1 : 3'd0;
      if ($urandom_range(0, 15) == 0) begin
        s.exc_valid = 1;
        s.exc_code = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
        s.exc_pc = $urandom; s.exc_bd = 1'($urandom); s.exc_bva = $urandom;
      end
      s.eret = ($urandom_range(0, 15) == 0);
      cyc(s);
    end

    @(negedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Parametrised successor of the CP0 register file.
- Sits in the MEM/WB stage. Holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config; drives the interrupt request and exception vector to the hazard/PC unit.
- New versus previous generation:
  - configurable interrupt-line count and Count prescaler;
  - register select field;
  - Status/Cause write masks;
  - nested-exception EPC protection;
  - registered interrupt request;
  - exception vector output.

Parameters:
- HW_INT_N, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_N-1:2].
- COUNT_DIV, 2, Count increments once every COUNT_DIV clk cycles (1..16).
- TIMER_LINE, 5, hardware line (0..5) that the timer flag ORs into, i.e. IP[TIMER_LINE+2].
- PRID_VAL, 32'h004C0102, PRId read value.
- CONFIG_VAL, 32'h00008000, Config read value.

Ports:
- clk in 1 clock.
- rst in 1 reset; asynchronous, active-high.
- we in 1 MTC0 write enable.
- waddr in 5 write register number.
- wsel in 3 write select.
- wdata in 32 write data.
- raddr in 5 read register number.
- rsel in 3 read select.
- rdata out 32 combinational read data.
- int_i in HW_INT_N hardware interrupts, level-sensitive.
- exc_valid in 1 exception commit this cycle.
- exc_code in 5 ExcCode of the committing exception.
- exc_pc in 32 PC of the excepting instruction.
- exc_bd in 1 excepting instruction is in a delay slot.
- exc_badvaddr in 32 faulting address.
- eret in 1 ERET commit.
- count_o out 32 Count.
- compare_o out 32 Compare.
- status_o out 32 Status.
- cause_o out 32 Cause.
- epc_o out 32 EPC.
- badvaddr_o out 32 BadVAddr.
- timer_int_o out 1 Cause.TI.
- int_req_o out 1 registered interrupt request.
- exc_vector_o out 32 exception handler address.

Behaviour:
- Register map (sel 0 unless stated): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Any other addr/sel reads 0; writes to it are ignored.
- Reset values (async, immediate):
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - Status = 32'h00400000 (BEV=1).
  - prescaler = 0.
  - timer_int_o = 0, int_req_o = 0.
  - exc_vector_o = 32'hBFC00380.
- Status writable bits: 22 (BEV), 15:8 (IM), 1 (EXL), 0 (IE). Other bits read 0.
- Cause writable bits via MTC0: 9:8 (IP1:0) only.
  - IP[2+k] <= int_i[k] registered every cycle; unused IP bits are 0.
  - IP[TIMER_LINE+2] is ORed with TI.
  - Bit 30 = TI. Bit 31 = BD. Bits 6:2 = ExcCode.
- Count prescaler: counts 0..COUNT_DIV-1. Count increments by 1 on the cycle the prescaler is at COUNT_DIV-1, and the prescaler wraps to 0. Count wraps 32'hFFFFFFFF -> 0. With COUNT_DIV=1, Count increments every cycle.
- MTC0 Count: loads wdata next cycle, resets prescaler to 0, and beats the increment.
- Timer: TI is set on any cycle where registered Count == Compare (including 0 == 0 after reset). TI is sticky and cleared only by a Compare write. A Compare write in the same cycle as a match clears TI.
- int_req_o: registered, 1-cycle latency. Next value = |(Cause.IP[7:0] & Status.IM) & Status.IE & ~Status.EXL.
- Exception (exc_valid=1):
  - If EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; BD <= exc_bd.
  - If EXL=1: EPC and BD are unchanged (nested exception).
  - Always: ExcCode <= exc_code; EXL <= 1.
  - BadVAddr <= exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
  - An MTC0 in the same cycle is discarded entirely, since the instruction is squashed.
- eret=1 with exc_valid=0: EXL <= 0. An MTC0 in the same cycle still applies, except that EXL ends at 0. When exc_valid and eret are both 1, exc_valid wins.
- exc_vector_o is combinational: BEV ? 32'hBFC00380 : 32'h80000180.
- Reads are combinational from current register state. A read of a register being written in the same cycle returns the old value.

Optional Feature:
- Macro CP0_EBASE_EN.
- When defined:
  - EBase exists at (15, sel 1), reset 32'h80000000.
  - Only bits 29:12 are writable; bit 31 reads 1; other bits read 0.
  - With BEV=0, exc_vector_o = {EBase[31:12], 12'h180}.
- When undefined: (15, sel 1) reads 0, writes are ignored, and the BEV=0 vector is fixed at 32'h80000180.

Test Plan:
- COUNT_DIV=2; release reset; run 20 cycles -> count_o = 10. MTC0 Count=32'hFFFFFFFF, then 2 cycles -> count_o = 0 (wrap).
- MTC0 Compare=5 (Count from 0) -> timer_int_o rises when count_o = 5 and holds. With Status=32'h00008001, int_req_o = 1 one cycle later. MTC0 Compare=100 -> TI = 0, then int_req_o = 0 next cycle.
- exc_valid, exc_code=4, exc_pc=32'hBFC00104, exc_bd=1, exc_badvaddr=32'h1003 -> EPC = 32'hBFC00100, Cause[31] = 1, Cause[6:2] = 4, BadVAddr = 32'h1003, Status[1] = 1.
- With EXL=1, exc_valid, exc_code=8, exc_pc=32'h80000200 -> EPC unchanged, ExcCode = 8, BadVAddr unchanged. Then eret -> Status[1] = 0.
- Same-cycle exc_valid and MTC0 Status=0 -> Status keeps IE/IM, EXL = 1. MTC0 Cause=32'hFFFFFFFF -> only bits 9:8 set.
- MTC0 Status=0 (BEV=0) -> exc_vector_o = 32'h80000180. Under CP0_EBASE_EN, MTC0 (15,1)=32'h9FC01000 -> EBase reads 32'h9FC01000, exc_vector_o = 32'h9FC01180.
